// File: rtl/puf_crp_checker.sv
// -----------------------------------------------------------------------------
// puf_crp_checker
// Initiator side of the RO_PUF challenge/response interface. A run issues N_CRP
// challenges (SEED+i, wrapping mod 2**CHAL_W) one at a time and collects each
// response. Enroll runs (MODE=0) store the responses in an internal CRP table;
// verify runs (MODE=1) compare each response against the table by Hamming
// distance and report PASS plus failure/distance statistics.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   START, MODE, SEED run request (sampled in IDLE), mode and base challenge
//   PUF_CHALLENGE     challenge presented to the PUF
//   PUF_START         1-cycle pulse, PUF starts evaluating PUF_CHALLENGE
//   PUF_RESPONSE      PUF response, valid while PUF_DONE=1
//   PUF_DONE          PUF result-valid level
//   BUSY              high from accepted START until DONE
//   DONE              1-cycle pulse at run end
//   PASS              run result, held until the next accepted START
//   FAIL_CNT          responses whose distance exceeded MAX_HD
//   HD_TOTAL          sum of Hamming distances over a verify run
//   TIMEOUT_ERR       run aborted because the PUF never answered
// -----------------------------------------------------------------------------
module puf_crp_checker #(
    parameter int CHAL_W  = 8,
    parameter int RESP_W  = 8,
    parameter int N_CRP   = 16,
    parameter int MAX_HD  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  START,
    input  logic                                  MODE,
    input  logic [CHAL_W-1:0]                     SEED,
    output logic [CHAL_W-1:0]                     PUF_CHALLENGE,
    output logic                                  PUF_START,
    input  logic [RESP_W-1:0]                     PUF_RESPONSE,
    input  logic                                  PUF_DONE,
    output logic                                  BUSY,
    output logic                                  DONE,
    output logic                                  PASS,
    output logic [$clog2(N_CRP+1)-1:0]            FAIL_CNT,
    output logic [$clog2(N_CRP*RESP_W+1)-1:0]     HD_TOTAL,
    output logic                                  TIMEOUT_ERR
);

    localparam int IDX_W = (N_CRP > 1) ? $clog2(N_CRP) : 1;
    localparam int FC_W  = $clog2(N_CRP + 1);
    localparam int HT_W  = $clog2(N_CRP * RESP_W + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CRP - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    function automatic logic [31:0] hamming(input logic [RESP_W-1:0] a,
                                            input logic [RESP_W-1:0] b);
        logic [31:0] n;
        n = '0;
        for (int k = 0; k < RESP_W; k++) begin
            n = n + 32'(a[k] ^ b[k]);
        end
        return n;
    endfunction

    logic [2:0]        state_q,    state_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic              mode_q,     mode_d;
    logic [CHAL_W-1:0] seed_q,     seed_d;
    logic              settle_q,   settle_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
    logic [RESP_W-1:0] resp_q,     resp_d;
    logic              pass_q,     pass_d;
    logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [HT_W-1:0]   hd_total_q, hd_total_d;
    logic              to_err_q,   to_err_d;
    logic              enrolled_q, enrolled_d;
    logic              bank_q,     bank_d;

    // Two table banks: an enroll run fills the inactive bank and only swaps it
    // in on successful completion, so an aborted enroll leaves the previously
    // enrolled table intact.
    logic [RESP_W-1:0] tab_q [2][N_CRP];
    logic              tab_we;
    logic [31:0]       hd;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        settle_d   = settle_q;
        to_cnt_d   = to_cnt_q;
        resp_d     = resp_q;
        pass_d     = pass_q;
        fail_cnt_d = fail_cnt_q;
        hd_total_d = hd_total_q;
        to_err_d   = to_err_q;
        enrolled_d = enrolled_q;
        bank_d     = bank_q;
        tab_we     = 1'b0;
        hd         = hamming(resp_q, tab_q[bank_q][idx_q]);

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mode_d     = MODE;
                    seed_d     = SEED;
                    idx_d      = '0;
                    pass_d     = 1'b0;
                    fail_cnt_d = '0;
                    hd_total_d = '0;
                    to_err_d   = 1'b0;
                    // Nothing to verify against: report failure immediately.
                    state_d    = (MODE && !enrolled_q) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                settle_d = 1'b0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                // PUF_DONE may still show the previous result here.
                if (settle_q) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end else begin
                    settle_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (PUF_DONE) begin
                    resp_d  = PUF_RESPONSE;
                    state_d = S_COMPARE;
                end else if (to_cnt_q == TO_LAST) begin
                    to_err_d = 1'b1;
                    pass_d   = 1'b0;
                    state_d  = S_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_COMPARE: begin
                if (mode_q) begin
                    hd_total_d = hd_total_q + HT_W'(hd);
                    if (hd > 32'(MAX_HD)) begin
                        fail_cnt_d = fail_cnt_q + FC_W'(1);
                    end
                end else begin
                    tab_we = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    // Result is settled on entry to FINISH so PASS is valid
                    // in the same cycle DONE pulses.
                    if (mode_q) begin
                        pass_d = (fail_cnt_d == '0);
                    end else begin
                        pass_d     = 1'b1;
                        enrolled_d = 1'b1;
                        bank_d     = ~bank_q;
                    end
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            mode_q     <= 1'b0;
            seed_q     <= '0;
            settle_q   <= 1'b0;
            to_cnt_q   <= '0;
            resp_q     <= '0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            hd_total_q <= '0;
            to_err_q   <= 1'b0;
            enrolled_q <= 1'b0;
            bank_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            seed_q     <= seed_d;
            settle_q   <= settle_d;
            to_cnt_q   <= to_cnt_d;
            resp_q     <= resp_d;
            pass_q     <= pass_d;
            fail_cnt_q <= fail_cnt_d;
            hd_total_q <= hd_total_d;
            to_err_q   <= to_err_d;
            enrolled_q <= enrolled_d;
            bank_q     <= bank_d;
        end
    end

    // Table contents need no reset; validity is tracked by enrolled_q.
    always_ff @(posedge CLK) begin
        if (tab_we) begin
            tab_q[~bank_q][idx_q] <= resp_q;
        end
    end

    // seed_q and idx_q only change outside ISSUE..COMPARE, so the challenge
    // stays stable for the whole PUF transaction.
    assign PUF_CHALLENGE = seed_q + CHAL_W'(idx_q);
    assign PUF_START     = (state_q == S_ISSUE);
    assign BUSY          = (state_q != S_IDLE);
    assign DONE          = (state_q == S_FINISH);
    assign PASS          = pass_q;
    assign FAIL_CNT      = fail_cnt_q;
    assign HD_TOTAL      = hd_total_q;
    assign TIMEOUT_ERR   = to_err_q;

endmodule

// File: tb/tb_puf_crp_checker.sv
module tb_puf_crp_checker;

    localparam int CHAL_W  = 8;
    localparam int RESP_W  = 8;
    localparam int N_CRP   = 16;
    localparam int MAX_HD  = 2;
    localparam int TIMEOUT = 20;
    localparam int L       = 5;
    localparam int RUN_CYC = N_CRP * (L + 2) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] puf_chal;
    logic       puf_start;
    logic [7:0] puf_resp = 8'h00;
    logic       puf_done = 1'b0;
    logic       busy, done, pass, to_err;
    logic [4:0] fail_cnt;
    logic [7:0] hd_total;

    always #5 clk = ~clk;

    puf_crp_checker #(
        .CHAL_W(CHAL_W), .RESP_W(RESP_W), .N_CRP(N_CRP),
        .MAX_HD(MAX_HD), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk), .RESET(rst), .START(start), .MODE(mode), .SEED(seed),
        .PUF_CHALLENGE(puf_chal), .PUF_START(puf_start),
        .PUF_RESPONSE(puf_resp), .PUF_DONE(puf_done),
        .BUSY(busy), .DONE(done), .PASS(pass),
        .FAIL_CNT(fail_cnt), .HD_TOTAL(hd_total), .TIMEOUT_ERR(to_err)
    );

    int checks   = 0;
    int failures = 0;

    // PUF behaviour: response = chal ^ 0xA5 ^ flip[chal]
    logic [7:0] flip [256];
    int         hang_at      = 0;
    int         pulses_total = 0;
    logic [7:0] chal_q [$];

    // Reference CRP table
    logic [7:0] ref_tab [N_CRP];
    logic       ref_enr = 1'b0;

    function automatic logic [7:0] puf_fn(input logic [7:0] c);
        return c ^ 8'hA5 ^ flip[c];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // PUF model: stale DONE is dropped 2 cycles after PUF_START, the new
    // result appears L cycles after PUF_START.
    initial begin
        int lat_cnt;
        int drop_cnt;
        logic [7:0] pend;
        lat_cnt = 0; drop_cnt = 0; pend = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                lat_cnt  = 0;
                drop_cnt = 0;
                puf_done = 1'b0;
            end else begin
                if (drop_cnt > 0) begin
                    drop_cnt--;
                    if (drop_cnt == 0) puf_done = 1'b0;
                end
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 0) begin
                        puf_done = 1'b1;
                        puf_resp = puf_fn(pend);
                    end
                end
                if (puf_start) begin
                    chal_q.push_back(puf_chal);
                    pulses_total++;
                    pend     = puf_chal;
                    drop_cnt = 2;
                    lat_cnt  = (pulses_total == hang_at) ? 0 : L;
                end
            end
        end
    end

    task automatic do_run(input string tag, input logic m, input logic [7:0] s, input int hang_rel);
        logic [7:0] new_tab [N_CRP];
        logic [7:0] c;
        int   exp_fc, exp_hd, exp_pulses, cyc, base, bad, hdv;
        logic exp_pass, exp_to, got;

        exp_fc = 0; exp_hd = 0; exp_pass = 1'b0; exp_to = 1'b0;
        new_tab = ref_tab;
        if (m && !ref_enr) begin
            exp_pulses = 0;
        end else begin
            exp_pulses = (hang_rel > 0) ? hang_rel : N_CRP;
            for (int i = 0; i < N_CRP; i++) begin
                if (hang_rel > 0 && i >= hang_rel - 1) break;
                c = s + 8'(i);
                new_tab[i] = puf_fn(c);
                if (m) begin
                    hdv = $countones(new_tab[i] ^ ref_tab[i]);
                    exp_hd += hdv;
                    if (hdv > MAX_HD) exp_fc++;
                end
            end
            if (hang_rel > 0) begin
                exp_to = 1'b1;
            end else if (!m) begin
                exp_pass = 1'b1;
                ref_tab  = new_tab;
                ref_enr  = 1'b1;
            end else begin
                exp_pass = (exp_fc == 0);
            end
        end

        base    = pulses_total;
        hang_at = (hang_rel > 0) ? base + hang_rel : 0;
        mode    = m;
        seed    = s;
        start   = 1'b1;
        cyc     = 0;
        got     = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                cyc = k;
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        if (!exp_to && exp_pulses == N_CRP) check({tag, "_latency"}, cyc, RUN_CYC);
        if (exp_pulses == 0) check({tag, "_fast_done"}, (cyc >= 1 && cyc <= 2), 1);
        check({tag, "_busy_at_done"}, busy, 1);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_fail_cnt"}, fail_cnt, exp_fc);
        check({tag, "_hd_total"}, hd_total, exp_hd);
        check({tag, "_timeout_err"}, to_err, exp_to);
        check({tag, "_puf_starts"}, pulses_total - base, exp_pulses);
        bad = 0;
        for (int i = 0; i < exp_pulses; i++) begin
            if (base + i >= chal_q.size()) bad++;
            else if (chal_q[base + i] !== s + 8'(i)) bad++;
        end
        check({tag, "_chal_order_errs"}, bad, 0);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_pass_held"}, pass, exp_pass);
        hang_at = 0;
    endtask

    initial begin
        logic [7:0] s;
        int   pcount, base, bad;
        logic saw_done, hit;

        for (int i = 0; i < 256; i++) flip[i] = 8'h00;
        for (int i = 0; i < N_CRP; i++) ref_tab[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_hd_total", hd_total, 0);
        check("rst_timeout_err", to_err, 0);
        check("rst_puf_start", puf_start, 0);
        check("rst_puf_chal", puf_chal, 0);
        rst = 1'b0;
        @(negedge clk);

        // Verify before any enrollment
        do_run("t3_unenrolled", 1'b1, 8'h00, 0);

        // Enroll then verify with a 2-bit (match) and a 3-bit (fail) flip
        do_run("t1_enroll", 1'b0, 8'h10, 0);
        flip[8'h13] = 8'h03;
        flip[8'h1A] = 8'h07;
        do_run("t2_verify", 1'b1, 8'h10, 0);
        check("t2_fail_cnt_abs", fail_cnt, 1);
        check("t2_hd_total_abs", hd_total, 5);
        flip[8'h13] = 8'h00;
        flip[8'h1A] = 8'h00;

        // Challenge wrap
        do_run("t4_enroll_wrap", 1'b0, 8'hF8, 0);
        do_run("t4_verify_wrap", 1'b1, 8'hF8, 0);

        // Timed-out enroll with corrupted responses must not disturb the table
        flip[8'hF8] = 8'hFF;
        flip[8'hF9] = 8'hFF;
        do_run("t5_enroll_timeout", 1'b0, 8'hF8, 3);
        flip[8'hF8] = 8'h00;
        flip[8'hF9] = 8'h00;
        do_run("t5_verify_old_table", 1'b1, 8'hF8, 0);
        check("t5_old_table_pass", pass, 1);

        // Randomized enroll/verify rounds with sparse random bit flips
        for (int r = 0; r < 4; r++) begin
            s = 8'($urandom);
            do_run("rnd_enroll", 1'b0, s, 0);
            for (int i = 0; i < N_CRP; i++) begin
                flip[s + 8'(i)] = 8'($urandom) & 8'($urandom) & 8'($urandom);
            end
            do_run("rnd_verify", 1'b1, s, 0);
            for (int i = 0; i < 256; i++) flip[i] = 8'h00;
        end

        // Reset during WAIT of the 5th challenge, STARTs pulsed while busy
        base     = pulses_total;
        pcount   = 0;
        saw_done = 1'b0;
        hit      = 1'b0;
        mode     = 1'b0;
        seed     = 8'h40;
        start    = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            start = (k == 10 || k == 20);
            if (start) begin
                seed = 8'h99;
                mode = 1'b1;
            end
            if (done) saw_done = 1'b1;
            if (puf_start) pcount++;
            if (pcount == 5) begin
                hit = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("t6_reached_5th", hit, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("t6_busy_in_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_pass", pass, 0);
        check("t6_rst_fail_cnt", fail_cnt, 0);
        check("t6_rst_hd_total", hd_total, 0);
        check("t6_rst_timeout_err", to_err, 0);
        check("t6_rst_puf_start", puf_start, 0);
        check("t6_rst_puf_chal", puf_chal, 0);
        check("t6_no_done", saw_done, 0);
        check("t6_puf_starts", pulses_total - base, 5);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (base + i >= chal_q.size()) bad++;
            else if (chal_q[base + i] !== 8'h40 + 8'(i)) bad++;
        end
        check("t6_chal_order_errs", bad, 0);
        @(negedge clk);
        rst     = 1'b0;
        ref_enr = 1'b0;
        @(negedge clk);
        do_run("t6_verify_after_reset", 1'b1, 8'h40, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
